// File: rtl/lift_pair_ctrl.sv
// Frame-based sample pairing: groups consecutive input samples into
// (even, odd) output pairs with first/last frame markers and valid/ready flow control.
module lift_pair_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned LW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] frame_len,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_even,
    output logic [DW-1:0] m_odd,
    output logic          m_first,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] pair_q;
    logic [LW-1:0] last_pair;
    logic [DW-1:0] even_q;
    logic          len_ok;
    logic          accept;
    logic          load;
    logic          consume;

    assign len_ok    = (frame_len != '0) && !frame_len[0];
    assign last_pair = (len_q >> 1) - LW'(1);

    // An odd-index sample completes a pair, so it may only enter when the output slot frees up.
    assign s_ready = (state == RUN) && (!idx_q[0] || !m_valid || m_ready);
    assign accept  = s_valid && s_ready;
    assign load    = accept && idx_q[0];
    assign consume = m_valid && m_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            pair_q  <= '0;
            even_q  <= '0;
            m_valid <= 1'b0;
            m_even  <= '0;
            m_odd   <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                idx_q   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                len_q  <= frame_len;
                                idx_q  <= '0;
                                pair_q <= '0;
                                state  <= RUN;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            idx_q <= idx_q + LW'(1);
                            if (!idx_q[0]) begin
                                even_q <= s_data;
                            end else begin
                                m_even  <= even_q;
                                m_odd   <= s_data;
                                m_first <= (pair_q == '0);
                                m_last  <= (pair_q == last_pair);
                                pair_q  <= pair_q + LW'(1);
                            end
                            if (idx_q == len_q - LW'(1)) begin
                                state <= DRAIN;
                            end
                        end
                        if (load) begin
                            m_valid <= 1'b1;
                        end else if (consume) begin
                            m_valid <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (consume) begin
                            m_valid <= 1'b0;
                            if (m_last) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lift_pair_ctrl.sv
// Self-checking bench for lift_pair_ctrl: per-cycle comparison against a sample-count
// based reference model, plus literal pair expectations for each directed scenario.
module tb_lift_pair_ctrl;
    localparam int DW = 16;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_even;
    logic [DW-1:0] m_odd;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    lift_pair_ctrl #(.DW(DW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_even(m_even), .m_odd(m_odd),
        .m_first(m_first), .m_last(m_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] e;
        logic [DW-1:0] o;
        logic          f;
        logic          l;
    } pair_t;

    int checks = 0;
    int failures = 0;
    pair_t got[$];
    pair_t exp_log[$];
    int done_cnt = 0;
    int blocked = 0;
    logic [DW-1:0] samp [0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress tracked as a count of accepted samples.
    bit            x_active = 0;
    bit            x_drain = 0;
    int            x_nacc = 0;
    int            x_flen = 0;
    logic [DW-1:0] x_held = '0;
    pair_t         x_out = '0;
    bit            x_ov = 0;
    bit            x_done = 0;
    bit            x_err = 0;

    always @(negedge clk) begin
        bit x_sready;
        bit nd;
        bit ne;
        if (!rst_n) begin
            x_active = 0; x_drain = 0; x_nacc = 0; x_flen = 0; x_held = '0;
            x_out = '0; x_ov = 0; x_done = 0; x_err = 0;
        end
        x_sready = x_active && ((x_nacc % 2 == 0) || !x_ov || m_ready);
        chk("s_ready", s_ready, x_sready);
        chk("m_valid", m_valid, x_ov);
        chk("busy", busy, x_active || x_drain);
        chk("done", done, x_done);
        chk("err", err, x_err);
        if (x_ov || !rst_n) begin
            chk("m_even", m_even, x_out.e);
            chk("m_odd", m_odd, x_out.o);
            chk("m_first", m_first, x_out.f);
            chk("m_last", m_last, x_out.l);
        end
        if (m_valid && m_ready) got.push_back('{m_even, m_odd, m_first, m_last});
        if (done) done_cnt++;
        if (s_valid && !s_ready && busy) blocked++;

        nd = 0;
        ne = 0;
        if (rst_n) begin
            if (abort && (x_active || x_drain)) begin
                x_active = 0; x_drain = 0; x_ov = 0; x_nacc = 0;
            end else if (!x_active && !x_drain) begin
                if (start) begin
                    if (frame_len != 0 && frame_len % 2 == 0) begin
                        x_active = 1; x_flen = int'(frame_len); x_nacc = 0;
                    end else begin
                        ne = 1;
                    end
                end
            end else begin
                if (x_ov && m_ready) begin
                    exp_log.push_back(x_out);
                    if (x_drain && x_out.l) begin
                        nd = 1;
                        x_drain = 0;
                    end
                    x_ov = 0;
                end
                if (x_active && s_valid && x_sready) begin
                    if (x_nacc % 2 == 0) begin
                        x_held = s_data;
                    end else begin
                        x_out = '{x_held, s_data, x_nacc == 1, x_nacc == x_flen - 1};
                        x_ov = 1;
                    end
                    x_nacc++;
                    if (x_nacc == x_flen) begin
                        x_active = 0;
                        x_drain = 1;
                    end
                end
            end
        end
        x_done = nd;
        x_err = ne;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        exp_log.delete();
        done_cnt = 0;
        blocked = 0;
    endtask

    task automatic do_start(input int len, input bit ab);
        frame_len = LW'(len);
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic pin(input int i, input logic [DW-1:0] e, input logic [DW-1:0] o,
                       input logic f, input logic l);
        pair_t want;
        want = '{e, o, f, l};
        if (i < got.size()) chk($sformatf("pair%0d_dut", i), got[i], want);
        else chk($sformatf("pair%0d_dut_missing", i), 0, 1);
        if (i < exp_log.size()) chk($sformatf("pair%0d_model", i), exp_log[i], want);
        else chk($sformatf("pair%0d_model_missing", i), 0, 1);
    endtask

    // Streams n samples; optional output stall, abort or reset after a given accepted count.
    task automatic feed(input int n, input int stall, input int ab_at, input int rst_at, input bit poke);
        int sent;
        int guard;
        int st;
        bit stalled;
        sent = 0; guard = 0; st = 0; stalled = 0;
        m_ready = 1'b1;
        s_valid = (n > 0);
        s_data = samp[0];
        if (poke) begin
            start = 1'b1;
            frame_len = LW'(3);
        end
        while (1) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            tick();
            guard++;
            if (ab_at >= 0 && sent == ab_at) begin
                abort = 1'b1;
                s_valid = 1'b0;
                tick();
                abort = 1'b0;
                m_ready = 1'b1;
                chk("abort_m_valid", m_valid, 0);
                chk("abort_busy", busy, 0);
                return;
            end
            if (rst_at >= 0 && sent == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_outputs", {s_ready, m_valid, m_first, m_last, busy, done, err}, 0);
                chk("rst_pair", {m_even, m_odd}, 0);
                tick();
                rst_n = 1'b1;
                s_valid = 1'b0;
                m_ready = 1'b1;
                return;
            end
            s_valid = (sent < n);
            s_data = (sent < n) ? samp[sent] : '0;
            if (stall > 0 && !stalled && m_valid) begin
                m_ready = 1'b0;
                st = stall;
                stalled = 1;
            end else if (st > 0) begin
                st--;
                if (st == 0) m_ready = 1'b1;
            end
            if (sent == n && !busy) begin
                start = 1'b0;
                break;
            end
            if (guard >= 200) begin
                start = 1'b0;
                chk("feed_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_state", {s_ready, m_valid, busy, done, err, m_first, m_last}, 0);
        chk("reset_pair", {m_even, m_odd}, 0);
        rst_n = 1'b1;
        tick();

        // Normal frame, with a start request held high (and odd length) while busy.
        clear_log();
        for (int i = 0; i < 8; i++) samp[i] = DW'(i + 1);
        do_start(8, 0);
        feed(8, 0, -1, -1, 1);
        tick();
        chk("normal_pairs", got.size(), 4);
        pin(0, 16'd1, 16'd2, 1, 0);
        pin(1, 16'd3, 16'd4, 0, 0);
        pin(2, 16'd5, 16'd6, 0, 0);
        pin(3, 16'd7, 16'd8, 0, 1);
        chk("normal_done", done_cnt, 1);

        // Backpressure after the first pair.
        clear_log();
        for (int i = 0; i < 8; i++) samp[i] = DW'(16'h10 + i);
        do_start(8, 0);
        feed(8, 5, -1, -1, 0);
        tick();
        chk("bp_pairs", got.size(), 4);
        pin(0, 16'h10, 16'h11, 1, 0);
        pin(1, 16'h12, 16'h13, 0, 0);
        pin(2, 16'h14, 16'h15, 0, 0);
        pin(3, 16'h16, 16'h17, 0, 1);
        chk("bp_blocked_cycles", blocked, 4);
        chk("bp_done", done_cnt, 1);

        // Rejected starts.
        s_valid = 1'b1;
        do_start(7, 0);
        chk("rej7_err", {err, busy, s_ready}, 3'b100);
        tick();
        chk("rej7_err_clear", {err, busy, s_ready}, 3'b000);
        do_start(0, 0);
        chk("rej0_err", {err, busy, s_ready}, 3'b100);
        tick();
        chk("rej0_err_clear", {err, busy, s_ready}, 3'b000);
        s_valid = 1'b0;

        // Minimum frame, started with abort high in IDLE.
        clear_log();
        samp[0] = 16'hAAAA;
        samp[1] = 16'h5555;
        do_start(2, 1);
        feed(2, 0, -1, -1, 0);
        tick();
        chk("min_pairs", got.size(), 1);
        pin(0, 16'hAAAA, 16'h5555, 1, 1);
        chk("min_done", done_cnt, 1);

        // Abort after 3 accepted samples, while the first pair is stalled.
        clear_log();
        for (int i = 0; i < 8; i++) samp[i] = DW'(16'h21 + i);
        do_start(8, 0);
        feed(8, 5, 3, -1, 0);
        repeat (3) tick();
        chk("abort_no_done", done_cnt, 0);
        clear_log();
        for (int i = 0; i < 4; i++) samp[i] = DW'(16'h61 + i);
        do_start(4, 0);
        feed(4, 0, -1, -1, 0);
        tick();
        chk("post_abort_pairs", got.size(), 2);
        pin(0, 16'h61, 16'h62, 1, 0);
        pin(1, 16'h63, 16'h64, 0, 1);
        chk("post_abort_done", done_cnt, 1);

        // Reset mid-frame, then a fresh frame.
        clear_log();
        for (int i = 0; i < 8; i++) samp[i] = DW'(16'h31 + i);
        do_start(8, 0);
        feed(8, 0, -1, 3, 0);
        repeat (2) tick();
        chk("rst_no_done", done_cnt, 0);
        clear_log();
        for (int i = 0; i < 4; i++) samp[i] = DW'(16'h41 + i);
        do_start(4, 0);
        feed(4, 0, -1, -1, 0);
        tick();
        chk("post_rst_pairs", got.size(), 2);
        pin(0, 16'h41, 16'h42, 1, 0);
        pin(1, 16'h43, 16'h44, 0, 1);
        chk("post_rst_done", done_cnt, 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lift_pair_ctrl.md
LIFT_PAIR_CTRL -- requirements
Module: lift_pair_ctrl

Interface
REQ-001 Parameter DW, default 16: sample width in bits.
REQ-002 Parameter LW, default 10: width of the frame-length and pair-count fields.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: frame start request; sampled only in IDLE.
REQ-006 Port abort, input, 1: synchronous frame cancel.
REQ-007 Port frame_len, input, LW: samples per frame; latched on accepted start.
REQ-008 Port s_valid, input, 1: input sample valid.
REQ-009 Port s_data, input, DW: input sample.
REQ-010 Port s_ready, output, 1: input sample accepted when s_valid && s_ready.
REQ-011 Port m_valid, output, 1: output pair valid.
REQ-012 Port m_ready, input, 1: output pair consumed when m_valid && m_ready.
REQ-013 Port m_even, output, DW: even-indexed sample of the pair (index 2k).
REQ-014 Port m_odd, output, DW: odd-indexed sample of the pair (index 2k+1).
REQ-015 Port m_first, output, 1: the pair is pair 0 of the frame.
REQ-016 Port m_last, output, 1: the pair is the final pair of the frame.
REQ-017 Port busy, output, 1: high in RUN and DRAIN.
REQ-018 Port done, output, 1: one-cycle pulse at frame completion.
REQ-019 Port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-021 IDLE: start with frame_len even and nonzero SHALL latch the length, clear the sample index and pair count, and go to RUN the next cycle.
REQ-022 IDLE: start with frame_len odd or zero SHALL pulse err for one cycle and remain in IDLE.
REQ-023 s_ready SHALL be 0 outside RUN.
REQ-024 In RUN, s_ready SHALL be 1 when the sample index is even; when it is odd, s_ready SHALL equal (!m_valid || m_ready).
REQ-025 An accepted even-index sample SHALL be held in an internal even register; the output pair SHALL be unchanged.
REQ-026 An accepted odd-index sample SHALL load m_even with the held even sample and m_odd with s_data, and SHALL set m_valid on the next edge.
REQ-027 m_first SHALL be 1 iff the loaded pair count is 0.
REQ-028 m_last SHALL be 1 iff the loaded pair count equals frame_len/2-1.
REQ-029 The sample index SHALL increment on each accepted sample.
REQ-030 On acceptance of sample frame_len-1, the FSM SHALL go to DRAIN.
REQ-031 m_valid SHALL clear on consume unless a new pair loads in the same cycle.
REQ-032 Consume and load in the same cycle SHALL give back-to-back pairs with no bubble.
REQ-033 m_even, m_odd, m_first and m_last SHALL hold stable while m_valid && !m_ready.
REQ-034 DRAIN: consumption of the m_last pair SHALL pulse done on the next cycle and return to IDLE.
REQ-035 frame_len = 2 SHALL produce one pair with m_first = m_last = 1.
REQ-036 The index and pair count SHALL never wrap within a frame.
REQ-037 abort SHALL have priority over all events: return to IDLE, clear m_valid, clear the index, and not pulse done.
REQ-038 abort in IDLE SHALL have no effect.
REQ-039 start outside IDLE SHALL be ignored.

Reset
REQ-040 While rst_n is low, the FSM SHALL be IDLE.
REQ-041 While rst_n is low, s_ready, m_valid, m_first, m_last, busy, done and err SHALL be 0, and m_even, m_odd and the internal registers SHALL be 0.
REQ-042 Reset mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Verification
REQ-043 Scenario, normal frame: frame_len = 8, samples 1..8, m_ready held 1 -> pairs (1,2)F, (3,4), (5,6), (7,8)L, then a done pulse and IDLE.
REQ-044 Scenario, backpressure: m_ready = 0 for 5 cycles after the first pair -> pair (1,2) stays stable, s_ready = 0 at the odd index, no sample lost or duplicated.
REQ-045 Scenario, rejected start: frame_len = 7 or 0 -> err pulse for 1 cycle, busy stays 0, s_ready stays 0.
REQ-046 Scenario, minimum frame: frame_len = 2, samples 0xAAAA, 0x5555 -> one pair with m_first = m_last = 1, then done.
REQ-047 Scenario, abort: abort after 3 accepted samples of frame_len = 8 -> m_valid = 0 next cycle, no done pulse; a new frame then restarts at pair 0 with m_first = 1.
REQ-048 Scenario, reset mid-frame: rst_n low mid-frame -> all outputs 0 immediately; a new start after release yields a correct fresh frame.
